// File: rtl/chacha_xor_stream.sv
// chacha_xor_stream
//   Consumes keystream bytes from the ChaCha block core's byte-read port and
//   XORs each one with a plaintext byte from a valid/ready stream.
//   Ciphertext leaves on a registered valid/ready stream.
//   After BLOCK_BYTES keystream bytes it pulses blk_req for one cycle.
//   The upstream loader then writes the next counter block into the core.
//
// Parameters
//   BLOCK_BYTES  keystream bytes per block (power of two, >= 2)
//
// Ports
//   clk       clock
//   rst_n     synchronous active-low reset
//   ks_ready  core has a keystream block available; ks_byte is valid
//   ks_byte   current keystream byte from the core
//   ks_read   one-cycle strobe; the core advances to its next byte
//   blk_req   one-cycle strobe; the upstream must load the next block
//   pt_data / pt_valid / pt_ready   plaintext input stream
//   ct_data / ct_valid / ct_ready   ciphertext output stream (registered)
//   flush     (only with CHACHA_XOR_FLUSH_EN) discard the rest of the block
//
// Build option
//   CHACHA_XOR_FLUSH_EN  adds the flush input. A flush seen in STREAM
//   discards all remaining keystream bytes of the current block and then
//   requests the next block.
module chacha_xor_stream #(
  parameter int BLOCK_BYTES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ks_ready,
  input  logic [7:0] ks_byte,
  output logic       ks_read,
  output logic       blk_req,
  input  logic [7:0] pt_data,
  input  logic       pt_valid,
  output logic       pt_ready,
  output logic [7:0] ct_data,
  output logic       ct_valid,
  input  logic       ct_ready
`ifdef CHACHA_XOR_FLUSH_EN
  ,
  input  logic       flush
`endif
);

  localparam int              CW   = (BLOCK_BYTES > 2) ? $clog2(BLOCK_BYTES) : 1;
  localparam logic [CW-1:0]   LAST = CW'(BLOCK_BYTES - 1);

  localparam logic [1:0] ST_WAIT   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_REQ    = 2'd2;
  localparam logic [1:0] ST_DROP   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]    ct_data_q, ct_data_d;
  logic          ct_valid_q, ct_valid_d;
  logic          flush_pend_q, flush_pend_d;

  logic          in_stream;
  logic          last_byte;
  logic          accept;
  logic          discard;

  always_comb begin
    in_stream = (state_q == ST_STREAM);
    last_byte = (byte_cnt_q == LAST);

`ifdef CHACHA_XOR_FLUSH_EN
    // Discarding waits until the output register is empty.
    // This keeps the last real ciphertext byte from being lost.
    discard = rst_n & in_stream & flush_pend_q & ~ct_valid_q & ks_ready;
`else
    discard = 1'b0;
`endif

    // The rst_n term keeps the strobes low during reset.
    // This matters even when the state register still holds STREAM.
    pt_ready = rst_n & in_stream & ks_ready & (~ct_valid_q | ct_ready) & ~flush_pend_q;
    accept   = pt_valid & pt_ready;
    ks_read  = accept | discard;
    blk_req  = rst_n & (state_q == ST_REQ);

    // BLOCK_BYTES is a power of two, so the counter wraps on its own.
    byte_cnt_d = byte_cnt_q;
    if (ks_read) begin
      byte_cnt_d = byte_cnt_q + 1'b1;
    end

    ct_data_d  = ct_data_q;
    ct_valid_d = ct_valid_q;
    if (accept) begin
      ct_data_d  = pt_data ^ ks_byte;
      ct_valid_d = 1'b1;
    end else if (ct_ready) begin
      ct_valid_d = 1'b0;
    end

    state_d = state_q;
    case (state_q)
      ST_WAIT:   if (ks_ready) state_d = ST_STREAM;
      ST_STREAM: if (ks_read && last_byte) state_d = ST_REQ;
      ST_REQ:    state_d = ST_DROP;
      ST_DROP:   if (!ks_ready) state_d = ST_WAIT;
      default:   state_d = ST_WAIT;
    endcase

`ifdef CHACHA_XOR_FLUSH_EN
    // The block-ending cycle always clears the pending flag.
    // A flush that coincides with the last byte therefore cannot carry
    // over into the next block.
    flush_pend_d = (flush_pend_q | (in_stream & flush)) & ~(in_stream & ks_read & last_byte);
`else
    flush_pend_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_WAIT;
      byte_cnt_q   <= '0;
      ct_data_q    <= 8'h00;
      ct_valid_q   <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      ct_data_q    <= ct_data_d;
      ct_valid_q   <= ct_valid_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign ct_data  = ct_data_q;
  assign ct_valid = ct_valid_q;

endmodule

// File: tb/tb_chacha_xor_stream.sv
// Testbench for chacha_xor_stream.
// A small core model serves keystream block 1 of the RFC 7539 section 2.4.2
// vector; later blocks are XORed with the block number.
// The stimulus process pushes expected ciphertext into a queue.
// A monitor pops the queue and compares on every ct handshake.
module tb_chacha_xor_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ks_ready;
  logic [7:0] ks_byte;
  logic       ks_read;
  logic       blk_req;
  logic [7:0] pt_data;
  logic       pt_valid;
  logic       pt_ready;
  logic [7:0] ct_data;
  logic       ct_valid;
  logic       ct_ready;
  logic       flush;

  chacha_xor_stream #(.BLOCK_BYTES(64)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ks_ready (ks_ready),
    .ks_byte  (ks_byte),
    .ks_read  (ks_read),
    .blk_req  (blk_req),
    .pt_data  (pt_data),
    .pt_valid (pt_valid),
    .pt_ready (pt_ready),
    .ct_data  (ct_data),
    .ct_valid (ct_valid),
    .ct_ready (ct_ready)
`ifdef CHACHA_XOR_FLUSH_EN
    ,
    .flush    (flush)
`endif
  );

  always #5 clk = ~clk;

  // RFC 7539 2.4.2 keystream, block counter 1, first 64 bytes.
  logic [7:0] ks_tbl [0:63] = '{
    8'h22, 8'h4f, 8'h51, 8'hf3, 8'h40, 8'h1b, 8'hd9, 8'he1,
    8'h2f, 8'hde, 8'h27, 8'h6f, 8'hb8, 8'h63, 8'h1d, 8'hed,
    8'h8c, 8'h13, 8'h1f, 8'h82, 8'h3d, 8'h2c, 8'h06, 8'he2,
    8'h7e, 8'h4f, 8'hca, 8'hec, 8'h9e, 8'hf3, 8'hcf, 8'h78,
    8'h8a, 8'h3b, 8'h0a, 8'ha3, 8'h72, 8'h60, 8'h0a, 8'h92,
    8'hb5, 8'h79, 8'h74, 8'hcd, 8'hed, 8'h2b, 8'h93, 8'h34,
    8'h79, 8'h4c, 8'hba, 8'h40, 8'hc6, 8'h3e, 8'h34, 8'hcd,
    8'hea, 8'h21, 8'h2c, 8'h4c, 8'hf0, 8'h7d, 8'h41, 8'hb7
  };

  // ---------------- core model ----------------
  logic [6:0] core_ptr = 7'd0;
  logic       core_loaded = 1'b1;
  logic [2:0] core_rl = 3'd0;
  logic [7:0] core_blk = 8'd0;
  logic       ks_gate;

  assign ks_ready = core_loaded & ~ks_gate;
  assign ks_byte  = ks_tbl[core_ptr[5:0]] ^ core_blk;

  always @(posedge clk) begin
    if (!rst_n) begin
      core_ptr    <= 7'd0;
      core_loaded <= 1'b1;
      core_rl     <= 3'd0;
    end else begin
      if (ks_read) begin
        core_ptr <= core_ptr + 7'd1;
        if (core_ptr == 7'd63) core_loaded <= 1'b0;
      end
      if (blk_req) begin
        core_rl <= 3'd4;
      end else if (core_rl != 3'd0) begin
        core_rl <= core_rl - 3'd1;
        if (core_rl == 3'd1) begin
          core_loaded <= 1'b1;
          core_ptr    <= 7'd0;
          core_blk    <= core_blk + 8'd1;
        end
      end
    end
  end

  // ---------------- counters / scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int ks_cnt = 0;
  int blk_cnt = 0;
  int blk_cyc = -1;
  int ctv_cnt = 0;
  int last_acc_cyc = 0;
  logic [7:0] exp_q [$];
  int exp_idx = 0;
  logic [7:0] exp_blk = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ks_read) ks_cnt++;
    if (blk_req) begin
      blk_cnt++;
      blk_cyc = cyc;
    end
    if (ct_valid) ctv_cnt++;
  end

  // Monitor: every ct handshake must match the oldest expected byte.
  always @(negedge clk) begin
    if (rst_n && ct_valid && ct_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL ct_unexpected: got %h with no expected byte queued", ct_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (ct_data !== e) begin
          n_err++;
          $display("FAIL ct_data: got %h expected %h", ct_data, e);
        end else begin
          $display("ct ok %h", ct_data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("check %s ok (%0h)", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one plaintext byte, wait (bounded) for acceptance, queue expected ct.
  task automatic send_exp(input logic [7:0] d, input logic [7:0] e);
    int guard;
    guard = 0;
    pt_data  = d;
    pt_valid = 1'b1;
    @(negedge clk);
    while (!pt_ready && guard < 300) begin
      tick();
      @(negedge clk);
      guard++;
    end
    if (!pt_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: pt_ready stayed %b, required 1", pt_ready);
    end else begin
      exp_q.push_back(e);
    end
    tick();
    last_acc_cyc = cyc;
    exp_idx++;
    if (exp_idx == 64) begin
      exp_idx = 0;
      exp_blk = exp_blk + 8'd1;
    end
  endtask

  task automatic send(input logic [7:0] d);
    send_exp(d, d ^ ks_tbl[exp_idx] ^ exp_blk);
  endtask

  task automatic idle(input int n);
    pt_valid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    int ks0, blk0, c0, guard;
    logic [7:0] hold_exp;
    rst_n = 1'b0; pt_data = 8'h00; pt_valid = 1'b0; ct_ready = 1'b1;
    ks_gate = 1'b0; flush = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_pt_ready", 32'(pt_ready), 32'd0);
    chk("rst_blk_req", 32'(blk_req), 32'd0);
    chk("rst_ct_valid", 32'(ct_valid), 32'd0);
    chk("rst_ct_data", 32'(ct_data), 32'd0);
    tick();
    rst_n = 1'b1;

    // Block 0: RFC vector start "Ladi", then 60 bytes back-to-back.
    ks0 = ks_cnt; blk0 = blk_cnt;
    send_exp(8'h4c, 8'h6e);
    send_exp(8'h61, 8'h2e);
    send_exp(8'h64, 8'h35);
    send_exp(8'h69, 8'h9a);
    c0 = cyc;
    for (int i = 4; i < 64; i++) send(8'(i * 37 + 5));
    chk("throughput_cycles", 32'(cyc - c0), 32'd60);
    idle(10);
    chk("blk0_ks_reads", 32'(ks_cnt - ks0), 32'd64);
    chk("blk0_blk_req_count", 32'(blk_cnt - blk0), 32'd1);
    chk("blk0_blk_req_cycle", 32'(blk_cyc), 32'(last_acc_cyc));

    // Block 1: output stall after byte 0.
    ct_ready = 1'b0;
    hold_exp = 8'hA5 ^ ks_tbl[exp_idx] ^ exp_blk;
    send(8'hA5);
    pt_data = 8'h3C; pt_valid = 1'b1;
    ks0 = ks_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_ct_valid", 32'(ct_valid), 32'd1);
      chk("stall_ct_data", 32'(ct_data), 32'(hold_exp));
      chk("stall_pt_ready", 32'(pt_ready), 32'd0);
      tick();
    end
    chk("stall_no_ks_read", 32'(ks_cnt - ks0), 32'd0);
    ct_ready = 1'b1;
    send(8'h3C);
    for (int i = 2; i < 20; i++) send(8'(i * 11 + 1));

    // Keystream gap at byte 20.
    ks_gate = 1'b1; pt_data = 8'h77; pt_valid = 1'b1;
    ks0 = ks_cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("gap_pt_ready", 32'(pt_ready), 32'd0);
      tick();
    end
    chk("gap_no_ks_read", 32'(ks_cnt - ks0), 32'd0);
    ks_gate = 1'b0;
    for (int i = 20; i < 30; i++) send(8'(i * 13 + 2));

    // Reset at byte 30 with a ciphertext byte still pending.
    blk0 = blk_cnt;
    ct_ready = 1'b0; rst_n = 1'b0; pt_data = 8'h55; pt_valid = 1'b1;
    @(negedge clk);
    chk("midrst_pt_ready", 32'(pt_ready), 32'd0);
    chk("midrst_ks_read", 32'(ks_read), 32'd0);
    tick();
    chk("midrst_ct_valid", 32'(ct_valid), 32'd0);
    chk("midrst_ct_data", 32'(ct_data), 32'd0);
    rst_n = 1'b1; pt_valid = 1'b0; ct_ready = 1'b1;
    exp_q.delete();
    exp_idx = 0;
    chk("midrst_no_blk_req", 32'(blk_cnt - blk0), 32'd0);

    // Full block after reset: count must restart from 0.
    ks0 = ks_cnt;
    for (int i = 0; i < 64; i++) send(8'(i * 3 + 9));
    idle(10);
    chk("blk2_ks_reads", 32'(ks_cnt - ks0), 32'd64);
    chk("blk2_blk_req_count", 32'(blk_cnt - blk0), 32'd1);
    chk("blk2_blk_req_cycle", 32'(blk_cyc), 32'(last_acc_cyc));

`ifdef CHACHA_XOR_FLUSH_EN
    for (int i = 0; i < 10; i++) send(8'(i + 100));
    idle(3);
    ks0 = ks_cnt; blk0 = blk_cnt; c0 = ctv_cnt;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    guard = 0;
    while (blk_cnt == blk0 && guard < 200) begin
      tick();
      guard++;
    end
    chk("flush_blk_req_seen", 32'(blk_cnt - blk0), 32'd1);
    chk("flush_ks_reads", 32'(ks_cnt - ks0), 32'd54);
    chk("flush_no_ct", 32'(ctv_cnt - c0), 32'd0);
    exp_idx = 0;
    exp_blk = exp_blk + 8'd1;
    for (int i = 0; i < 4; i++) send(8'(i + 200));
`endif

    idle(1);
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      tick();
      guard++;
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
